lcd_bus_reader: RTL and testbench
=================================

# lcd_bus_reader

Read-side engine for the HD44780-compatible 16x2 character LCD on the board's 8-bit parallel bus. It complements the existing write-only LCD initialisation and text path. On request it runs one correctly timed bus read cycle (RW=1): either a busy-flag/address-counter read (RS=0) or a DDRAM/CGRAM data read (RS=1). In poll mode it repeats busy-flag reads until the controller is ready or a timeout expires. It sits beside the LCD writer under the top level. The top level owns the `LCD_DATA` tristate and releases the bus whenever `oRD_ACTIVE` is high.

## Interface
- `T_AS`, default 8: address-setup cycles, RS/RW valid before EN rises (≥140 ns at 50 MHz).
- `T_EN`, default 25: EN-high cycles (≥450 ns, covers 320 ns data delay).
- `T_H`, default 2: hold cycles after EN falls, RW/RS held.
- `T_GAP`, default 16: recovery cycles before the next access (full cycle ≥1000 ns).
- `MAX_POLLS`, default 1000: busy-flag reads before timeout in poll mode.
- `iCLK`  in  1  system clock, 50 MHz.
- `iRST`  in  1  synchronous, active-high reset.
- `iSTART`  in  1  request pulse; sampled only in IDLE.
- `iRS`  in  1  register select for a single read (0 = BF/AC, 1 = data).
- `iPOLL`  in  1  with `iSTART`: poll BF until clear; forces RS=0.
- `LCD_DATA_IN`  in  8  bus value from the top-level tristate.
- `LCD_RW`  out  1  read/write select.
- `LCD_EN`  out  1  enable strobe.
- `LCD_RS`  out  1  register select.
- `oRD_ACTIVE`  out  1  top must not drive `LCD_DATA`.
- `oBUSY`  out  1  transaction in progress.
- `oDONE`  out  1  one-cycle completion pulse.
- `oDATA`  out  8  last sampled byte.
- `oBF`  out  1  `oDATA[7]` when the last read had RS=0.
- `oAC`  out  7  `oDATA[6:0]` when the last read had RS=0.
- `oTIMEOUT`  out  1  valid with `oDONE`; poll exhausted `MAX_POLLS`.

## Operation
- States: IDLE, SETUP, EN_HI, HOLD, GAP.
- Reset values: all outputs 0; state IDLE; poll counter 0.
- **IDLE.** Outputs: RW=0, EN=0, `oRD_ACTIVE`=0, `oBUSY`=0.
  - `iSTART`=1 latches RS (RS=0 if `iPOLL`) and the poll flag, then goes to SETUP.
- **SETUP.** RW=1, RS=latched, EN=0, `oRD_ACTIVE`=1, `oBUSY`=1. Lasts `T_AS` cycles, then EN_HI.
- **EN_HI.** EN=1 for `T_EN` cycles.
  - `LCD_DATA_IN` is registered into `oDATA` on the final EN_HI cycle only.
- **HOLD.** EN=0; RW/RS held; `oRD_ACTIVE`=1. Lasts `T_H` cycles, then GAP.
- **GAP.** RW=0, RS=0, `oRD_ACTIVE`=0, `oBUSY`=1. Lasts `T_GAP` cycles, then IDLE or repeats SETUP.
  - Single read: `oDONE`=1 on the first GAP cycle.
  - Poll read with BF=1 and count+1 < `MAX_POLLS`: count increments; no `oDONE`; GAP returns to SETUP.
  - Poll read with BF=0: `oDONE`=1, `oTIMEOUT`=0.
  - Poll read where the `MAX_POLLS`-th read still has BF=1: `oDONE`=1, `oTIMEOUT`=1.
- `oBF`/`oAC` update only on RS=0 reads. `oDATA` updates on every read. All three hold until the next sample.
- `iSTART` outside IDLE is ignored (no queueing). Input changes mid-transaction are ignored.
- Reset mid-operation: next edge gives IDLE with all outputs 0; EN drops without completing the cycle.
- Poll counter width: `$clog2(MAX_POLLS+1)`. Phase counter width: `$clog2(max(T_AS,T_EN,T_H,T_GAP)+1)`. Both saturate-free because they reload per phase.

## Timing
- Cycle 0 is the `iSTART` accept edge.
- SETUP occupies cycles 1..`T_AS`.
- EN_HI occupies cycles `T_AS`+1..`T_AS`+`T_EN`.
- HOLD follows for `T_H` cycles.
- Single-read `oDONE` lands at cycle `T_AS`+`T_EN`+`T_H`+1, which is 36 with defaults.
- Next `iSTART` is accepted at cycle `T_AS`+`T_EN`+`T_H`+`T_GAP`+1, which is 52 with defaults.
- Each poll iteration adds 51 cycles with defaults.
- RS/RW change only while EN=0.
- `oRD_ACTIVE` rises with RW and falls with it.

## Structure
- Package `lcd_pkg` holds:
  - the state enum (IDLE, SETUP, EN_HI, HOLD, GAP);
  - default timing constants, shared with the LCD writer;
  - RS encodings (CMD=0, DATA=1).
- One sub-module, `lcd_phase_timer`: loadable down-counter with a `done` flag, reloaded on every state entry.

## Test plan
- Single BF read: `iSTART`=1, `iRS`=0, bus model drives 0x25 → `oDONE` at cycle 36, `oBF`=0, `oAC`=0x25. EN high for exactly 25 cycles. RW=1 from cycle 1 to cycle 35.
- Data read: `iRS`=1, bus 0x41 → `oDATA`=0x41. `oBF`/`oAC` unchanged from the previous read.
- Poll: bus returns BF=1 for 3 reads, then 0x00 → exactly one `oDONE` at cycle 3·51+36=189, `oTIMEOUT`=0.
- Timeout: `MAX_POLLS`=4, BF held at 1 → `oDONE` with `oTIMEOUT`=1 after the 4th read at cycle 189. No 5th EN pulse.
- `iSTART` pulsed at cycles 10 and 51 → both ignored. The pulse at cycle 52 is accepted.
- `iRST` asserted during EN_HI → next cycle EN=0, RW=0, `oBUSY`=0, `oDATA`=0. A new `iSTART` after reset runs a normal cycle.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus engines (reader and writer).
// Holds the read-engine state encoding, the default bus timing in 50 MHz
// clock cycles, the RS encodings and a small helper used to size the phase
// timer.
package lcd_pkg;

  // Read-engine states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EN_HI = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } lcd_rd_state_e;

  // Default bus timing in 50 MHz cycles (20 ns each).
  localparam int LCD_T_AS      = 8;     // RS/RW setup before EN rises, >=140 ns
  localparam int LCD_T_EN      = 25;    // EN high, >=450 ns, covers 320 ns data delay
  localparam int LCD_T_H       = 2;     // RS/RW hold after EN falls
  localparam int LCD_T_GAP     = 16;    // recovery so a full cycle is >=1000 ns
  localparam int LCD_MAX_POLLS = 1000;  // busy-flag reads before giving up

  // Register-select encodings.
  localparam logic LCD_RS_CMD  = 1'b0;  // busy flag / address counter
  localparam logic LCD_RS_DATA = 1'b1;  // DDRAM / CGRAM data

  // Largest of four phase lengths; sizes the shared phase counter.
  function automatic int lcd_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// Request / LCD-bus bundle for lcd_bus_reader.
//   requester side : iSTART, iRS, iPOLL in; oBUSY, oDONE, oDATA, oBF, oAC,
//                    oTIMEOUT, oRD_ACTIVE back
//   LCD pins       : LCD_RW, LCD_EN, LCD_RS out; LCD_DATA_IN from the
//                    top-level tristate
// The 'slave' modport is the reader engine; 'master' is the top level /
// requester that also owns the LCD_DATA tristate.
interface lcd_bus_reader_if;

  logic       iSTART;
  logic       iRS;
  logic       iPOLL;
  logic [7:0] LCD_DATA_IN;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;
  logic       oRD_ACTIVE;
  logic       oBUSY;
  logic       oDONE;
  logic [7:0] oDATA;
  logic       oBF;
  logic [6:0] oAC;
  logic       oTIMEOUT;

  modport master (
    output iSTART, iRS, iPOLL, LCD_DATA_IN,
    input  LCD_RW, LCD_EN, LCD_RS, oRD_ACTIVE, oBUSY, oDONE,
    input  oDATA, oBF, oAC, oTIMEOUT
  );

  modport slave (
    input  iSTART, iRS, iPOLL, LCD_DATA_IN,
    output LCD_RW, LCD_EN, LCD_RS, oRD_ACTIVE, oBUSY, oDONE,
    output oDATA, oBF, oAC, oTIMEOUT
  );

endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter timing one bus phase.
//   iCLK, iRST : clock, synchronous active-high reset
//   load       : reload with load_val (phase length minus one)
//   load_val   : cycles to count after the load cycle
//   done       : counter has reached zero, i.e. the current phase cycle is
//                the last one of the phase
module lcd_phase_timer #(
  parameter int W = 5
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Count down to zero and park there until the next phase reloads.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign done = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/lcd_bus_reader.sv
// Read-side engine for the HD44780-style character LCD parallel bus.
// Runs one timed read cycle (RW=1) per request: busy-flag/address-counter
// (RS=0) or data (RS=1). In poll mode it repeats busy-flag reads until BF
// clears or MAX_POLLS reads have been made.
//   iCLK, iRST : 50 MHz clock, synchronous active-high reset
//   bus        : request handshake, results and LCD pins (slave modport)
// All outputs are registered; each state's outputs are set on the edge
// that enters it, so a phase of N cycles shows N cycles on the pins.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_AS      = LCD_T_AS,
  parameter int T_EN      = LCD_T_EN,
  parameter int T_H       = LCD_T_H,
  parameter int T_GAP     = LCD_T_GAP,
  parameter int MAX_POLLS = LCD_MAX_POLLS
) (
  input logic            iCLK,
  input logic            iRST,
  lcd_bus_reader_if.slave bus
);

  localparam int PW = $clog2(lcd_max4(T_AS, T_EN, T_H, T_GAP) + 1);
  localparam int CW = $clog2(MAX_POLLS + 1);
  // Counter value while the MAX_POLLS-th read is in flight.
  localparam logic [CW-1:0] LAST_POLL = CW'(MAX_POLLS - 1);

  lcd_rd_state_e state_r;
  logic          rs_r;      // RS latched at request time
  logic          poll_r;    // request was a poll
  logic          again_r;   // GAP goes back to SETUP instead of IDLE
  logic [CW-1:0] polls_r;   // completed busy reads minus one in this poll

  logic          load_s;
  logic [PW-1:0] load_val_s;
  logic          done_s;

  lcd_phase_timer #(.W(PW)) u_timer (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .load     (load_s),
    .load_val (load_val_s),
    .done     (done_s)
  );

  // Reload the phase timer with the length of the phase being entered.
  always_comb begin
    load_s     = 1'b0;
    load_val_s = {PW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (bus.iSTART) begin
          load_s     = 1'b1;
          load_val_s = PW'(T_AS - 1);
        end else begin
          load_s     = 1'b0;
        end
      end
      ST_SETUP: begin
        load_s     = done_s;
        load_val_s = PW'(T_EN - 1);
      end
      ST_EN_HI: begin
        load_s     = done_s;
        load_val_s = PW'(T_H - 1);
      end
      ST_HOLD: begin
        load_s     = done_s;
        load_val_s = PW'(T_GAP - 1);
      end
      ST_GAP: begin
        // Only matters when looping back for another poll read.
        load_s     = done_s;
        load_val_s = PW'(T_AS - 1);
      end
      default: begin
        load_s     = 1'b0;
        load_val_s = {PW{1'b0}};
      end
    endcase
  end

  // Sequencer with registered bus pins and results.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r        <= ST_IDLE;
      rs_r           <= LCD_RS_CMD;
      poll_r         <= 1'b0;
      again_r        <= 1'b0;
      polls_r        <= {CW{1'b0}};
      bus.LCD_RW     <= 1'b0;
      bus.LCD_EN     <= 1'b0;
      bus.LCD_RS     <= 1'b0;
      bus.oRD_ACTIVE <= 1'b0;
      bus.oBUSY      <= 1'b0;
      bus.oDONE      <= 1'b0;
      bus.oDATA      <= 8'h00;
      bus.oBF        <= 1'b0;
      bus.oAC        <= 7'h00;
      bus.oTIMEOUT   <= 1'b0;
    end else begin
      bus.oDONE <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.iSTART) begin
            // Polling always reads the busy flag.
            rs_r           <= bus.iPOLL ? LCD_RS_CMD : bus.iRS;
            bus.LCD_RS     <= bus.iPOLL ? LCD_RS_CMD : bus.iRS;
            poll_r         <= bus.iPOLL;
            polls_r        <= {CW{1'b0}};
            again_r        <= 1'b0;
            bus.LCD_RW     <= 1'b1;
            bus.oRD_ACTIVE <= 1'b1;
            bus.oBUSY      <= 1'b1;
            state_r        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (done_s) begin
            bus.LCD_EN <= 1'b1;
            state_r    <= ST_EN_HI;
          end
        end
        ST_EN_HI: begin
          if (done_s) begin
            // Sample on the last EN-high cycle, while data is still driven.
            bus.LCD_EN <= 1'b0;
            bus.oDATA  <= bus.LCD_DATA_IN;
            if (rs_r == LCD_RS_CMD) begin
              bus.oBF <= bus.LCD_DATA_IN[7];
              bus.oAC <= bus.LCD_DATA_IN[6:0];
            end
            state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (done_s) begin
            bus.LCD_RW     <= 1'b0;
            bus.LCD_RS     <= 1'b0;
            bus.oRD_ACTIVE <= 1'b0;
            state_r        <= ST_GAP;
            // oDATA holds the byte just read; decide whether we are finished.
            if (!poll_r || !bus.oDATA[7]) begin
              bus.oDONE    <= 1'b1;
              bus.oTIMEOUT <= 1'b0;
              again_r      <= 1'b0;
            end else if (polls_r != LAST_POLL) begin
              polls_r <= polls_r + {{(CW-1){1'b0}}, 1'b1};
              again_r <= 1'b1;
            end else begin
              bus.oDONE    <= 1'b1;
              bus.oTIMEOUT <= 1'b1;
              again_r      <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (done_s) begin
            if (again_r) begin
              bus.LCD_RW     <= 1'b1;
              bus.LCD_RS     <= rs_r;
              bus.oRD_ACTIVE <= 1'b1;
              state_r        <= ST_SETUP;
            end else begin
              bus.oBUSY <= 1'b0;
              state_r   <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: default-timing instance plus a
// MAX_POLLS=4 instance for the timeout case. Cycle c below is the
// observation taken after clock edge c-1, edge 0 being the iSTART accept.
module tb_lcd_bus_reader;

  logic CLOCK_50;
  logic rst;
  logic sel;          // 0: default DUT, 1: MAX_POLLS=4 DUT
  logic start;
  logic drv_rs;
  logic drv_poll;
  logic [7:0] bus_val;

  int checks;
  int errors;

  lcd_bus_reader_if b0 ();
  lcd_bus_reader_if b1 ();

  lcd_bus_reader u_dut0 (.iCLK(CLOCK_50), .iRST(rst), .bus(b0));
  lcd_bus_reader #(.MAX_POLLS(4)) u_dut1 (.iCLK(CLOCK_50), .iRST(rst), .bus(b1));

  assign b0.iSTART      = start & ~sel;
  assign b1.iSTART      = start & sel;
  assign b0.iRS         = drv_rs;
  assign b1.iRS         = drv_rs;
  assign b0.iPOLL       = drv_poll;
  assign b1.iPOLL       = drv_poll;
  assign b0.LCD_DATA_IN = bus_val;
  assign b1.LCD_DATA_IN = bus_val;

  logic       o_en, o_rw, o_rs, o_act, o_busy, o_done, o_bf, o_to;
  logic [7:0] o_data;
  logic [6:0] o_ac;
  assign o_en   = sel ? b1.LCD_EN     : b0.LCD_EN;
  assign o_rw   = sel ? b1.LCD_RW     : b0.LCD_RW;
  assign o_rs   = sel ? b1.LCD_RS     : b0.LCD_RS;
  assign o_act  = sel ? b1.oRD_ACTIVE : b0.oRD_ACTIVE;
  assign o_busy = sel ? b1.oBUSY      : b0.oBUSY;
  assign o_done = sel ? b1.oDONE      : b0.oDONE;
  assign o_bf   = sel ? b1.oBF        : b0.oBF;
  assign o_to   = sel ? b1.oTIMEOUT   : b0.oTIMEOUT;
  assign o_data = sel ? b1.oDATA      : b0.oDATA;
  assign o_ac   = sel ? b1.oAC        : b0.oAC;

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Per-run statistics.
  int pulses, en_cyc, en_first, rw_first, rw_last, rs_cyc, busy_last;
  int act_bad, seq_bad, done_cnt, done_first, done_last;
  logic to_at_done;
  logic s_en, s_rw, s_busy, s_act;
  logic [7:0] s_data;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  // One request at edge 0, then ncyc observed cycles. Reads 1..bf_reads
  // return 0x85 (BF=1, AC=5); everything else returns val. Extra iSTART
  // pulses at edges x0/x1/x2; iRST asserted across edge rst_at.
  task automatic run(input logic rs, input logic poll, input int bf_reads,
                     input logic [7:0] val, input int ncyc,
                     input int x0, input int x1, input int x2, input int rst_at);
    logic p_en, p_rw, p_rs;
    pulses = 0; en_cyc = 0; en_first = -1; rw_first = -1; rw_last = -1;
    rs_cyc = 0; busy_last = -1; act_bad = 0; seq_bad = 0;
    done_cnt = 0; done_first = -1; done_last = -1; to_at_done = 1'b0;
    p_en = 1'b0; p_rw = 1'b0; p_rs = 1'b0;
    drv_rs = rs; drv_poll = poll;
    bus_val = (bf_reads > 0) ? 8'h85 : val;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (o_en && !p_en) pulses = pulses + 1;
      if (o_en) begin
        en_cyc = en_cyc + 1;
        if (en_first < 0) en_first = c;
      end
      if (o_rw) begin
        if (rw_first < 0) rw_first = c;
        rw_last = c;
      end
      if (o_rs) rs_cyc = rs_cyc + 1;
      if (o_busy) busy_last = c;
      if (o_act !== o_rw) act_bad = act_bad + 1;
      if (((o_rw !== p_rw) || (o_rs !== p_rs)) && (o_en || p_en)) seq_bad = seq_bad + 1;
      if (o_done) begin
        done_cnt = done_cnt + 1;
        if (done_first < 0) done_first = c;
        done_last = c;
        to_at_done = o_to;
      end
      if (c == rst_at + 1) begin
        s_en = o_en; s_rw = o_rw; s_busy = o_busy; s_act = o_act; s_data = o_data;
        rst = 1'b0;
      end
      p_en = o_en; p_rw = o_rw; p_rs = o_rs;
      bus_val = (pulses >= 1 && pulses <= bf_reads) ? 8'h85 : val;
      start = (c == x0) || (c == x1) || (c == x2);
      if (c == rst_at) rst = 1'b1;
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; sel = 1'b0; start = 1'b0; drv_rs = 1'b0; drv_poll = 1'b0; bus_val = 8'h00;
    tick();
    tick();
    check_eq("rst_rw",   {31'd0, o_rw},   32'd0);
    check_eq("rst_en",   {31'd0, o_en},   32'd0);
    check_eq("rst_act",  {31'd0, o_act},  32'd0);
    check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst_done", {31'd0, o_done}, 32'd0);
    check_eq("rst_data", {24'd0, o_data}, 32'd0);
    check_eq("rst_to",   {31'd0, o_to},   32'd0);
    rst = 1'b0;
    tick();

    // Single busy-flag read, bus 0x25.
    run(1'b0, 1'b0, 0, 8'h25, 60, -1, -1, -1, -1);
    check_eq("bf_done_cyc",  done_first, 36);
    check_eq("bf_done_cnt",  done_cnt,   1);
    check_eq("bf_en_cyc",    en_cyc,     25);
    check_eq("bf_en_first",  en_first,   9);
    check_eq("bf_rw_first",  rw_first,   1);
    check_eq("bf_rw_last",   rw_last,    35);
    check_eq("bf_rs_cyc",    rs_cyc,     0);
    check_eq("bf_busy_last", busy_last,  51);
    check_eq("bf_act_bad",   act_bad,    0);
    check_eq("bf_seq_bad",   seq_bad,    0);
    check_eq("bf_bf",        {31'd0, o_bf},   32'd0);
    check_eq("bf_ac",        {25'd0, o_ac},   32'h25);
    check_eq("bf_data",      {24'd0, o_data}, 32'h25);

    // Data read, bus 0x41: BF/AC keep the previous busy read.
    run(1'b1, 1'b0, 0, 8'h41, 60, -1, -1, -1, -1);
    check_eq("dr_done_cyc", done_first, 36);
    check_eq("dr_rs_cyc",   rs_cyc,     35);
    check_eq("dr_seq_bad",  seq_bad,    0);
    check_eq("dr_data",     {24'd0, o_data}, 32'h41);
    check_eq("dr_ac",       {25'd0, o_ac},   32'h25);
    check_eq("dr_bf",       {31'd0, o_bf},   32'd0);

    // Poll: three busy reads then ready; iRS=1 must be overridden.
    run(1'b1, 1'b1, 3, 8'h00, 210, -1, -1, -1, -1);
    check_eq("pl_done_cyc",  done_first, 189);
    check_eq("pl_done_cnt",  done_cnt,   1);
    check_eq("pl_timeout",   {31'd0, to_at_done}, 32'd0);
    check_eq("pl_pulses",    pulses,     4);
    check_eq("pl_rs_cyc",    rs_cyc,     0);
    check_eq("pl_busy_last", busy_last,  204);
    check_eq("pl_seq_bad",   seq_bad,    0);
    check_eq("pl_ac",        {25'd0, o_ac}, 32'h00);

    // Timeout on the MAX_POLLS=4 instance: BF never clears.
    sel = 1'b1;
    run(1'b0, 1'b1, 1000, 8'h85, 260, -1, -1, -1, -1);
    check_eq("to_done_cyc", done_first, 189);
    check_eq("to_done_cnt", done_cnt,   1);
    check_eq("to_timeout",  {31'd0, to_at_done}, 32'd1);
    check_eq("to_pulses",   pulses,     4);
    check_eq("to_bf",       {31'd0, o_bf}, 32'd1);
    check_eq("to_ac",       {25'd0, o_ac}, 32'h05);
    sel = 1'b0;

    // iSTART at edges 10 and 51 ignored; 52 accepted.
    run(1'b0, 1'b0, 0, 8'h3A, 110, 10, 51, 52, -1);
    check_eq("ig_en_first",   en_first,   9);
    check_eq("ig_done_first", done_first, 36);
    check_eq("ig_done_last",  done_last,  88);
    check_eq("ig_done_cnt",   done_cnt,   2);
    check_eq("ig_pulses",     pulses,     2);
    check_eq("ig_busy_last",  busy_last,  103);

    // Reset during EN high, then a normal read.
    run(1'b0, 1'b0, 0, 8'h5C, 30, -1, -1, -1, 20);
    check_eq("rs_en_seen",  en_cyc,   12);
    check_eq("rs_en",       {31'd0, s_en},   32'd0);
    check_eq("rs_rw",       {31'd0, s_rw},   32'd0);
    check_eq("rs_busy",     {31'd0, s_busy}, 32'd0);
    check_eq("rs_act",      {31'd0, s_act},  32'd0);
    check_eq("rs_data",     {24'd0, s_data}, 32'd0);
    check_eq("rs_done_cnt", done_cnt, 0);
    run(1'b0, 1'b0, 0, 8'h5C, 60, -1, -1, -1, -1);
    check_eq("ar_done_cyc", done_first, 36);
    check_eq("ar_en_cyc",   en_cyc,     25);
    check_eq("ar_data",     {24'd0, o_data}, 32'h5C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
